// File: rtl/hazard_pkg.sv
// Shared types for the five-stage hazard controller: forwarding selects,
// memory-wait FSM states and the per-stage control shadow.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic is_load;
    logic mem_access;
    logic use_rs1;
    logic use_rs2;
  } stage_ctl_t;

  localparam int WCNT_W = 8;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand EX forwarding comparator; the M stage result is younger than W
// and therefore wins when both match.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_use,
  input  logic [ADDR_WIDTH-1:0] i_rs,
  input  logic [ADDR_WIDTH-1:0] i_m_rd,
  input  logic                  i_m_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_w_rd,
  input  logic                  i_w_reg_write,
  output fwd_sel_t              o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_use && (i_rs != '0)) begin
      if (i_m_reg_write && (i_m_rd == i_rs))      o_sel = FWD_MEM;
      else if (i_w_reg_write && (i_w_rd == i_rs)) o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the F/D/E/M/W pipeline: shadows in-flight register
// fields, drives forwarding, load-use/branch/memory stalls and event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_mem_access,
  input  logic                  ex_pc_src,
  input  logic                  dmem_ready,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  mem_err,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  stage_ctl_t                       r_e, r_m, r_w, w_d_ctl;
  logic [ADDR_WIDTH-1:0]            r_e_rd, r_m_rd, r_w_rd;
  logic [1:0][ADDR_WIDTH-1:0]       r_e_rs;
  logic [1:0]                       w_e_use;
  fwd_sel_t                         w_fwd [2];
  mem_state_t                       r_state, w_state_nxt;
  logic [WCNT_W-1:0]                r_wcnt, w_wcnt_nxt;
  logic                             r_abort, w_timeout, r_mem_err;
  logic                             w_mem_stall, w_lu_hit, w_any_stall;
  logic [CNT_WIDTH-1:0]             r_stall_cnt, r_flush_cnt;
  logic                             w_unused_w;

  assign w_e_use = {r_e.use_rs2, r_e.use_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd (
      .i_use         (w_e_use[gi]),
      .i_rs          (r_e_rs[gi]),
      .i_m_rd        (r_m_rd),
      .i_m_reg_write (r_m.reg_write),
      .i_w_rd        (r_w_rd),
      .i_w_reg_write (r_w.reg_write),
      .o_sel         (w_fwd[gi])
    );
  end

  assign fwd_a_e = w_fwd[0];
  assign fwd_b_e = w_fwd[1];

  // After a timeout the stuck access is released for one cycle so it can leave M.
  assign w_mem_stall = r_m.mem_access && !dmem_ready && !r_abort;

  assign w_lu_hit = r_e.is_load && (r_e_rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == r_e_rd)) ||
                     (id_use_rs2 && (id_rs2 == r_e_rd)));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (w_mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (ex_pc_src) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (w_lu_hit) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign w_any_stall = stall_f | stall_d | stall_e | stall_m;

  always_comb begin
    w_d_ctl            = '0;
    w_d_ctl.valid      = id_valid;
    w_d_ctl.reg_write  = id_valid & id_reg_write;
    w_d_ctl.is_load    = id_valid & id_is_load;
    w_d_ctl.mem_access = id_valid & id_mem_access;
    w_d_ctl.use_rs1    = id_valid & id_use_rs1;
    w_d_ctl.use_rs2    = id_valid & id_use_rs2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e    <= '0;
      r_m    <= '0;
      r_w    <= '0;
      r_e_rd <= '0;
      r_m_rd <= '0;
      r_w_rd <= '0;
      r_e_rs <= '0;
    end else begin
      if (!stall_e) begin
        if (flush_e) begin
          r_e    <= '0;
          r_e_rd <= '0;
          r_e_rs <= '0;
        end else begin
          r_e    <= w_d_ctl;
          r_e_rd <= id_rd;
          r_e_rs <= {id_rs2, id_rs1};
        end
      end
      if (!stall_m) begin
        r_m    <= r_e;
        r_m_rd <= r_e_rd;
      end
      if (flush_w) begin
        r_w    <= '0;
        r_w_rd <= '0;
      end else begin
        r_w    <= r_m;
        r_w_rd <= r_m_rd;
      end
    end
  end

  // Wait counter holds the number of stall cycles already spent on this access.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_timeout   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = MEMWAIT;
          w_wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (!w_mem_stall) begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
          w_timeout   = 1'b1;
        end else begin
          w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_wcnt    <= '0;
      r_abort   <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_abort   <= w_timeout;
      r_mem_err <= r_mem_err | w_timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (flush_d && (r_flush_cnt != '1))     r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // W shadow fields beyond reg_write/rd are carried for completeness only.
  assign w_unused_w = ^r_w;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage (F/D/E/M/W) successor of the single-cycle RV32I core. It shadows the destination/source register fields of every in-flight instruction and drives EX-stage forwarding selects. It generates load-use stalls, taken-branch/jump flushes and whole-pipeline stalls while the data memory is not ready. Saturating stall/flush event counters are exposed for performance measurement.

## Interface
- `ADDR_WIDTH`, 5, register index width
- `MEM_TIMEOUT`, 16, maximum MEMWAIT cycles before abort (2..255)
- `CNT_WIDTH`, 32, width of the performance counters
- `clk  in  1  core clock, all state on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `id_valid  in  1  D stage holds a real instruction`
- `id_rs1, id_rs2  in  ADDR_WIDTH  D-stage source indices`
- `id_use_rs1, id_use_rs2  in  1  instruction actually reads the source`
- `id_rd  in  ADDR_WIDTH  D-stage destination`
- `id_reg_write  in  1  D-stage RegWrite`
- `id_is_load  in  1  D-stage ResultSrc selects memory`
- `id_mem_access  in  1  D-stage load or store`
- `ex_pc_src  in  1  branch taken / jump resolved in E`
- `dmem_ready  in  1  data memory completes access this cycle`
- `stall_f, stall_d, stall_e, stall_m  out  1  hold stage register`
- `flush_d, flush_e, flush_w  out  1  bubble into stage register`
- `fwd_a_e, fwd_b_e  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result`
- `mem_err  out  1  sticky memory-timeout flag`
- `stall_cnt, flush_cnt  out  CNT_WIDTH  saturating event counters`

## Operation
- Internal shadows per stage E, M, W: valid, rd, reg_write, is_load, mem_access; E also rs1/rs2/use bits. Advance D→E→M→W on each edge unless the stage is stalled; a flushed stage loads all-zero (bubble).
- Forwarding (per operand, E stage): if use bit set and rs≠0: M match with M.reg_write → 10; else W match with W.reg_write → 01; else 00. M takes priority over W. x0 never forwarded.
- Load-use: E.is_load && E.rd≠0 && E.rd matches a used D source && id_valid → stall_f, stall_d, flush_e.
- Control flush: ex_pc_src → flush_d, flush_e; no load-use stall that cycle (D is wrong-path).
- FSM states RUN, MEMWAIT. RUN→MEMWAIT when M.mem_access && !dmem_ready. MEMWAIT→RUN on dmem_ready or when wait counter reaches MEM_TIMEOUT-1 (then set mem_err). Memory stall (M.mem_access && !dmem_ready, in either state, until release) → stall_f/d/e/m, flush_w; overrides load-use and flush (ex_pc_src is held in E and honoured after release).
- Priority: memory stall > control flush > load-use.
- stall_cnt +1 per cycle with any stall_* asserted; flush_cnt +1 per cycle with flush_d; both saturate at all-ones.

## Timing
- Reset: all shadows invalid, reg_write 0; state RUN; wait counter 0; mem_err 0; counters 0; all stall/flush outputs 0; fwd selects 00.
- Stall, flush and forwarding outputs are combinational from inputs and current shadows/state, valid in the same cycle; shadows, FSM, counters update at the edge.
- Load-use costs exactly one bubble; taken branch costs two.
- Timeout: with dmem_ready held low, stall lasts exactly MEM_TIMEOUT cycles, mem_err rises on the last edge, pipeline advances next cycle.
- Reset mid-MEMWAIT aborts immediately to RUN with all shadows cleared.

## Structure
- Package `hazard_pkg`: fwd_sel_t enum (FWD_RF, FWD_WB, FWD_MEM), mem_state_t enum (RUN, MEMWAIT), stage shadow struct.
- Sub-module `fwd_sel`: combinational per-operand comparator, instantiated twice (A, B).

## Test plan
- `add x5` in M, `sub` in E reading x5 as rs1 → fwd_a_e=10; same rd also in W → still 10.
- `lw x6` in E, D reads x6 → stall_f=stall_d=flush_e=1 one cycle, next cycle fwd from W = 01.
- Load-use with ex_pc_src=1 same cycle → flush_d=flush_e=1, stall_d=0, flush_cnt +1.
- Store in M, dmem_ready low 3 cycles → stall_f..stall_m and flush_w high 3 cycles, stall_cnt +3, mem_err 0.
- dmem_ready held low, MEM_TIMEOUT=4 → stall exactly 4 cycles, mem_err=1 and sticky; rst_n low mid-wait → all outputs 0 asynchronously.
- Instruction writing x0 in M, E reads x0 → fwd selects 00.
